// File: rtl/micro_sequencer.sv
// Microprogram sequencer: sole writer of the control address register (CAR).
// Optional single-step hold after each retired instruction: `define SINGLE_STEP_EN.
module micro_sequencer #(
    parameter int unsigned SZ       = 22,
    parameter int unsigned N        = 7,
    parameter int unsigned STEP     = 4,
    parameter int unsigned OPW      = 4,
    parameter int unsigned WMFC_BIT = 8,
    parameter int unsigned SEL_BIT  = 16,
    parameter int unsigned END_BIT  = 21,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           halt_req,
    input  logic [OPW-1:0] opcode,
    input  logic [SZ-1:0]  cbr,
    input  logic           mfc,
    input  logic           step,
    output logic [N-1:0]   car,
    output logic           busy,
    output logic           stalled,
    output logic           instr_done,
    output logic           illegal_op,
    output logic           mem_timeout,
    output logic           seq_fault,
    output logic [15:0]    retired
);

`ifdef SINGLE_STEP_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_STEP_HOLD} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_e;
`endif

    state_e       state_q;
    logic [N-1:0] car_q;
    logic         busy_q, stalled_q, done_q, ill_q, tmo_q, flt_q, halt_q;
    logic [15:0]  retired_q;
    logic [7:0]   cnt_q;

    logic         halt_pend, wmfc_stall, op_illegal, adv_en;
    logic [N-1:0] car_d;
    logic         done_d, ill_d, flt_d;
    state_e       next_state_d;
    logic         unused_bits;

    assign unused_bits = ^{cbr, step};
    assign halt_pend   = halt_q | halt_req;
    assign wmfc_stall  = cbr[WMFC_BIT] & ~mfc;
    assign op_illegal  = (32'(opcode) == 32'd0) || (32'(opcode) == 32'd8);
    assign adv_en      = ((state_q == S_RUN) && !wmfc_stall) || ((state_q == S_WAIT) && mfc);

    // Steps 2-4 of word execution, shared by RUN and by WAIT once mfc arrives.
    always_comb begin
        car_d        = car_q + 1'b1;
        done_d       = 1'b0;
        ill_d        = 1'b0;
        flt_d        = 1'b0;
        next_state_d = S_RUN;
        if (cbr[END_BIT]) begin
            car_d  = '0;
            done_d = 1'b1;
            if (halt_pend) begin
                next_state_d = S_IDLE;
            end else begin
`ifdef SINGLE_STEP_EN
                next_state_d = S_STEP_HOLD;
`else
                next_state_d = S_RUN;
`endif
            end
        end else if (cbr[SEL_BIT]) begin
            if (op_illegal) begin
                car_d = '0;
                ill_d = 1'b1;
            end else begin
                car_d = N'(32'(opcode) * STEP);
            end
        end else if (&car_q) begin
            flt_d = 1'b1;
        end
    end

    // The trailing adv_en block overrides the per-state defaults on advance cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            car_q     <= '0;
            busy_q    <= 1'b0;
            stalled_q <= 1'b0;
            done_q    <= 1'b0;
            ill_q     <= 1'b0;
            tmo_q     <= 1'b0;
            flt_q     <= 1'b0;
            halt_q    <= 1'b0;
            retired_q <= '0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            ill_q  <= 1'b0;
            tmo_q  <= 1'b0;
            flt_q  <= 1'b0;
            halt_q <= halt_pend;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (wmfc_stall) begin
                        state_q   <= S_WAIT;
                        stalled_q <= 1'b1;
                        cnt_q     <= 8'd1;
                    end
                end
                S_WAIT: begin
                    if (!mfc) begin
                        if (cnt_q == 8'(TIMEOUT)) begin
                            car_q     <= '0;
                            tmo_q     <= 1'b1;
                            stalled_q <= 1'b0;
                            state_q   <= S_RUN;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
`ifdef SINGLE_STEP_EN
                S_STEP_HOLD: begin
                    if (halt_pend) begin
                        state_q <= S_IDLE;
                        halt_q  <= 1'b0;
                    end else if (step || start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
            if (adv_en) begin
                car_q     <= car_d;
                done_q    <= done_d;
                ill_q     <= ill_d;
                flt_q     <= flt_d;
                stalled_q <= 1'b0;
                state_q   <= next_state_d;
                busy_q    <= (next_state_d == S_RUN);
                if (done_d) begin
                    retired_q <= retired_q + 16'd1;
                    if (halt_pend) halt_q <= 1'b0;
                end
            end
        end
    end

    assign car         = car_q;
    assign busy        = busy_q;
    assign stalled     = stalled_q;
    assign instr_done  = done_q;
    assign illegal_op  = ill_q;
    assign mem_timeout = tmo_q;
    assign seq_fault   = flt_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: per-cycle stimulus and expected outputs are queued, then replayed.
module tb_micro_sequencer;

    localparam logic [21:0] W_WMFC = 22'h000100;
    localparam logic [21:0] W_SEL  = 22'h010000;
    localparam logic [21:0] W_END  = 22'h200000;
    // flag order: {busy, stalled, instr_done, illegal_op, mem_timeout, seq_fault}
    localparam logic [5:0] F_0 = 6'b000000;
    localparam logic [5:0] F_B = 6'b100000;
    localparam logic [5:0] F_S = 6'b010000;
    localparam logic [5:0] F_D = 6'b001000;
    localparam logic [5:0] F_I = 6'b000100;
    localparam logic [5:0] F_T = 6'b000010;
    localparam logic [5:0] F_F = 6'b000001;

    logic        clk, rst, start, halt_req, mfc, step;
    logic [3:0]  opcode;
    logic [21:0] cbr;
    logic [6:0]  car;
    logic        busy, stalled, instr_done, illegal_op, mem_timeout, seq_fault;
    logic [15:0] retired;
    logic [21:0] rom [128];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst, start, halt, mfc, stp;
        logic [3:0]  op;
        logic [6:0]  car;
        logic [5:0]  flg;
        logic [15:0] ret;
    } ent_t;
    ent_t sb[$];

    logic       s_rst, s_start, s_halt, s_mfc, s_step;
    logic [3:0] s_op;

    micro_sequencer #(.SZ(22), .N(7), .STEP(4), .OPW(4), .WMFC_BIT(8),
                      .SEL_BIT(16), .END_BIT(21), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .opcode(opcode),
        .cbr(cbr), .mfc(mfc), .step(step), .car(car), .busy(busy), .stalled(stalled),
        .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
        .seq_fault(seq_fault), .retired(retired)
    );

    assign cbr = rom[car];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic cyc(input logic [6:0] c, input logic [5:0] f, input logic [15:0] r);
        ent_t e;
        e.rst = s_rst; e.start = s_start; e.halt = s_halt; e.mfc = s_mfc; e.stp = s_step;
        e.op = s_op; e.car = c; e.flg = f; e.ret = r;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        ent_t e;
        int   idx = 0;
        logic [5:0] flg;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst = e.rst; start = e.start; halt_req = e.halt;
            mfc = e.mfc; step = e.stp; opcode = e.op;
            flg = {busy, stalled, instr_done, illegal_op, mem_timeout, seq_fault};
            total++;
            if (car !== e.car) begin
                bad++;
                $display("FAIL %s[%0d] car: got %0d want %0d", name, idx, car, e.car);
            end
            total++;
            if (flg !== e.flg) begin
                bad++;
                $display("FAIL %s[%0d] flags: got %b want %b", name, idx, flg, e.flg);
            end
            total++;
            if (retired !== e.ret) begin
                bad++;
                $display("FAIL %s[%0d] retired: got %0d want %0d", name, idx, retired, e.ret);
            end
            @(posedge clk); #1;
            idx++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; halt_req = 1'b0; mfc = 1'b1; step = 1'b0; opcode = '0;
        s_rst = 1'b0; s_start = 1'b0; s_halt = 1'b0; s_mfc = 1'b1; s_step = 1'b0; s_op = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_prefix(input logic [3:0] op);
        s_op = op; s_start = 1'b1;
        cyc(7'd0, F_0, 16'd0);
        s_start = 1'b0;
        cyc(7'd0, F_B, 16'd0);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (car !== 7'd0) begin bad++; $display("FAIL reset car: got %0d want 0", car); end
        total++;
        if ({busy, stalled, instr_done, illegal_op, mem_timeout, seq_fault} !== F_0) begin
            bad++; $display("FAIL reset flags: got %b want 000000",
                            {busy, stalled, instr_done, illegal_op, mem_timeout, seq_fault});
        end
        total++;
        if (retired !== 16'd0) begin bad++; $display("FAIL reset retired: got %0d want 0", retired); end
    endtask

    task automatic test_fetch();
        do_reset();
        run_prefix(4'd1);
        for (int i = 1; i <= 6; i++) cyc(7'(i), F_B, 16'd0);
        cyc(7'd0, F_B | F_D, 16'd1);
        drain("fetch");
    endtask

    task automatic test_stall();
        do_reset();
        run_prefix(4'd1);
        s_mfc = 1'b0;
        cyc(7'd1, F_B, 16'd0);
        cyc(7'd1, F_B | F_S, 16'd0);
        cyc(7'd1, F_B | F_S, 16'd0);
        s_mfc = 1'b1;
        cyc(7'd1, F_B | F_S, 16'd0);
        cyc(7'd2, F_B, 16'd0);
        cyc(7'd3, F_B, 16'd0);
        drain("stall");
    endtask

    task automatic test_timeout();
        do_reset();
        run_prefix(4'd1);
        s_mfc = 1'b0;
        cyc(7'd1, F_B, 16'd0);
        for (int i = 0; i < 15; i++) cyc(7'd1, F_B | F_S, 16'd0);
        cyc(7'd0, F_B | F_T, 16'd0);
        cyc(7'd1, F_B, 16'd0);
        cyc(7'd1, F_B | F_S, 16'd0);
        drain("timeout");
    endtask

    task automatic test_illegal();
        do_reset();
        run_prefix(4'd8);
        cyc(7'd1, F_B, 16'd0);
        cyc(7'd2, F_B, 16'd0);
        cyc(7'd3, F_B, 16'd0);
        s_op = 4'd13;
        cyc(7'd0, F_B | F_I, 16'd0);
        cyc(7'd1, F_B, 16'd0);
        cyc(7'd2, F_B, 16'd0);
        cyc(7'd3, F_B, 16'd0);
        cyc(7'd52, F_B, 16'd0);
        s_op = 4'd0;
        cyc(7'd0, F_B | F_D, 16'd1);
        cyc(7'd1, F_B, 16'd1);
        cyc(7'd2, F_B, 16'd1);
        cyc(7'd3, F_B, 16'd1);
        cyc(7'd0, F_B | F_I, 16'd1);
        drain("illegal");
    endtask

    task automatic test_seq_fault();
        do_reset();
        run_prefix(4'd15);
        for (int i = 1; i <= 3; i++) cyc(7'(i), F_B, 16'd0);
        for (int a = 60; a <= 127; a++) cyc(7'(a), F_B, 16'd0);
        cyc(7'd0, F_B | F_F, 16'd0);
        drain("seq_fault");
    endtask

    task automatic test_halt(input int at);
        do_reset();
        run_prefix(4'd5);
        for (int i = 1; i <= 3; i++) cyc(7'(i), F_B, 16'd0);
        s_halt = (at == 5);
        cyc(7'd20, F_B, 16'd0);
        s_halt = (at == 6);
        cyc(7'd21, F_B, 16'd0);
        s_halt = 1'b0;
        cyc(7'd0, F_D, 16'd1);
        cyc(7'd0, F_0, 16'd1);
        s_start = 1'b1;
        cyc(7'd0, F_0, 16'd1);
        s_start = 1'b0;
        cyc(7'd0, F_B, 16'd1);
        cyc(7'd1, F_B, 16'd1);
        drain(at == 5 ? "halt_early" : "halt_same");
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        run_prefix(4'd1);
        for (int i = 1; i <= 6; i++) cyc(7'(i), F_B, 16'd0);
        cyc(7'd0, F_B | F_D, 16'd1);
        s_mfc = 1'b0;
        cyc(7'd1, F_B, 16'd1);
        s_rst = 1'b1;
        cyc(7'd1, F_B | F_S, 16'd1);
        s_rst = 1'b0;
        cyc(7'd0, F_0, 16'd0);
        cyc(7'd0, F_0, 16'd0);
        drain("rst_in_wait");
    endtask

    task automatic test_single_step();
        do_reset();
        run_prefix(4'd1);
        for (int i = 1; i <= 6; i++) cyc(7'(i), F_B, 16'd0);
        cyc(7'd0, F_D, 16'd1);
        s_step = 1'b1;
        cyc(7'd0, F_0, 16'd1);
        s_step = 1'b0;
        cyc(7'd0, F_B, 16'd1);
        for (int i = 1; i <= 6; i++) cyc(7'(i), F_B, 16'd1);
        cyc(7'd0, F_D, 16'd2);
        s_halt = 1'b1;
        cyc(7'd0, F_0, 16'd2);
        s_halt = 1'b0; s_step = 1'b1;
        cyc(7'd0, F_0, 16'd2);
        s_step = 1'b0;
        cyc(7'd0, F_0, 16'd2);
        drain("single_step");
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = '0;
        rom[1]  = W_WMFC;
        rom[3]  = W_SEL;
        rom[6]  = W_END;
        rom[21] = W_END;
        rom[52] = W_END;

        test_reset();
        test_stall();
        test_timeout();
        test_seq_fault();
        test_halt(5);
        test_halt(6);
`ifdef SINGLE_STEP_EN
        test_single_step();
`else
        test_fetch();
        test_illegal();
        test_reset_in_wait();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
